// File: rtl/d_mem_arbiter.sv
// -----------------------------------------------------------------------------
// d_mem_arbiter
//
// Purpose:
//   Shares the single address/write port of the 256x16 data memory between
//   two requesters: port A (CPU load/store path) and port B (debug/DMA host).
//   Each access takes a one-cycle SERVE phase (address/write presented to the
//   memory) followed by a one-cycle ACK phase (completion strobe to the
//   requester). Arbitration is round-robin, or fixed A-priority with a
//   starvation limit that forces a B grant after STARVE_MAX consecutive A
//   grants while B is waiting.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   prio_a_i     1 = fixed A priority with starvation limit, 0 = round-robin
//   a_req_i      port A request (level, held until a_ack_o)
//   a_we_i       port A write (1) / read (0)
//   a_addr_i     port A address
//   a_wdata_i    port A write data
//   a_ack_o      port A one-cycle completion strobe
//   a_rdata_o    port A read data, valid while a_ack_o is high
//   b_*          same as port A, for port B
//   mem_addr_o   memory address
//   mem_we_o     memory write enable
//   mem_wdata_o  memory write data
//   mem_rdata_i  memory read data (combinational from mem_addr_o)
//   busy_o       high in any state other than IDLE
// -----------------------------------------------------------------------------
module d_mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prio_a_i,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_ack_o,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_ack_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_A = 3'd1,
        SERVE_B = 3'd2,
        ACK_A   = 3'd3,
        ACK_B   = 3'd4
    } state_t;

    state_t              state_q,     state_d;
    logic                last_b_q,    last_b_d;     // 1: last grant went to B
    logic [3:0]          starve_q,    starve_d;
    logic                we_q,        we_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic                mem_we_q,    mem_we_d;
    logic                a_ack_q,     a_ack_d;
    logic                b_ack_q,     b_ack_d;
    logic [DATA_W-1:0]   a_rdata_q,   a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q,   b_rdata_d;
    logic                busy_q,      busy_d;

    logic                tie_to_b_s;
    logic                grant_a_s;
    logic                grant_b_s;

    // Tie-break when both ports request: priority mode only yields to B once
    // A has used up its allowance; round-robin hands the tie to whoever did
    // not win last time.
    assign tie_to_b_s = prio_a_i ? (starve_q == STARVE_LIM) : ~last_b_q;
    assign grant_a_s  = a_req_i & (~b_req_i | ~tie_to_b_s);
    assign grant_b_s  = b_req_i & (~a_req_i |  tie_to_b_s);

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        starve_d  = starve_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_we_d  = 1'b0;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        busy_d    = 1'b0;

        case (state_q)
            // Arbitration points: a request seen here (including one still
            // held through an ACK cycle) is granted straight away.
            IDLE, ACK_A, ACK_B: begin
                if (grant_a_s) begin
                    state_d  = SERVE_A;
                    last_b_d = 1'b0;
                    we_d     = a_we_i;
                    addr_d   = a_addr_i;
                    wdata_d  = a_wdata_i;
                    mem_we_d = a_we_i;
                end else if (grant_b_s) begin
                    state_d  = SERVE_B;
                    last_b_d = 1'b1;
                    we_d     = b_we_i;
                    addr_d   = b_addr_i;
                    wdata_d  = b_wdata_i;
                    mem_we_d = b_we_i;
                end else begin
                    state_d  = IDLE;
                end

                // Count A grants that happen while B is left waiting; any
                // pause in B's request, a B grant, or round-robin mode clears.
                if (!prio_a_i || !b_req_i || grant_b_s) begin
                    starve_d = 4'd0;
                end else if (starve_q != STARVE_LIM) begin
                    starve_d = starve_q + 4'd1;
                end else begin
                    starve_d = starve_q;
                end
            end

            // The write commits and read data is captured at the edge
            // leaving SERVE; a write leaves the old read data in place.
            SERVE_A: begin
                state_d = ACK_A;
                a_ack_d = 1'b1;
                if (!we_q) begin
                    a_rdata_d = mem_rdata_i;
                end else begin
                    a_rdata_d = a_rdata_q;
                end
            end

            SERVE_B: begin
                state_d = ACK_B;
                b_ack_d = 1'b1;
                if (!we_q) begin
                    b_rdata_d = mem_rdata_i;
                end else begin
                    b_rdata_d = b_rdata_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; async reset aborts any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            starve_q  <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            mem_we_q  <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= {DATA_W{1'b0}};
            b_rdata_q <= {DATA_W{1'b0}};
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            starve_q  <= starve_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mem_we_q  <= mem_we_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            busy_q    <= busy_d;
        end
    end

    assign a_ack_o     = a_ack_q;
    assign b_ack_o     = b_ack_q;
    assign a_rdata_o   = a_rdata_q;
    assign b_rdata_o   = b_rdata_q;
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = busy_q;

endmodule
